exu_alu_arb: RTL

- Shares one exu_alu instance between N_REQ requesters, e.g. the EXU main path and the AGU/branch-compare path.
- Each requester has a valid/ready request channel and a valid/ready response channel.
- Grants at most one request per cycle, round-robin, and drives the ALU combinationally.
- Registers the ALU result into a per-requester response slot; the result is visible one cycle after acceptance.

---
 rtl/exu_alu_arb_pkg.sv | 23 ++
 rtl/exu_alu_arb_rr_pick.sv | 35 +++
 rtl/exu_alu_arb.sv | 83 ++++++++
 3 files changed

// File: rtl/exu_alu_arb_pkg.sv
// rtl/exu_alu_arb_pkg.sv - shared ALU select encoding and arbiter limits
package exu_alu_arb_pkg;

    localparam int ALU_SEL_W   = 10;
    localparam int ALU_ADD_SUB = 0;
    localparam int ALU_SUB     = 1;
    localparam int ALU_SLT     = 2;
    localparam int ALU_SLTU    = 3;
    localparam int ALU_AND     = 4;
    localparam int ALU_OR      = 5;
    localparam int ALU_XOR     = 6;
    localparam int ALU_SLL     = 7;
    localparam int ALU_SRL     = 8;
    localparam int ALU_SRA     = 9;

    localparam int N_REQ_MAX   = 4;

    // Pointer width for an n-way round-robin; never narrower than one bit.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/exu_alu_arb_rr_pick.sv
// rtl/exu_alu_arb_rr_pick.sv - N-wide round-robin priority picker
import exu_alu_arb_pkg::*;

module rr_pick #(
    parameter int N  = 2,
    parameter int PW = ptr_width(N)
) (
    input  logic [N-1:0]  eligible,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] grant_idx,
    output logic          any
);

    // Scan from ptr upward, wrapping, and stop at the first eligible index.
    always_comb begin
        int j;
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        j         = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!any && eligible[j]) begin
                any       = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = PW'(j);
            end
        end
    end

endmodule

// File: rtl/exu_alu_arb.sv
// rtl/exu_alu_arb.sv - round-robin sharing of one combinational ALU among N_REQ requesters
import exu_alu_arb_pkg::*;

module exu_alu_arb #(
    parameter int N_REQ = 2,
    parameter int XLEN  = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ-1:0]           req_inst_32,
    input  logic [N_REQ*ALU_SEL_W-1:0] req_op,
    input  logic [N_REQ*XLEN-1:0]      req_a,
    input  logic [N_REQ*XLEN-1:0]      req_b,
    output logic [N_REQ-1:0]           rsp_valid,
    input  logic [N_REQ-1:0]           rsp_ready,
    output logic [N_REQ*XLEN-1:0]      rsp_result,
    output logic                       alu_inst_32,
    output logic [XLEN-1:0]            alu_a,
    output logic [XLEN-1:0]            alu_b,
    output logic [ALU_SEL_W-1:0]       alu_sel,
    input  logic [XLEN-1:0]            alu_result
);

    localparam int PW = ptr_width(N_REQ);

    logic [PW-1:0]    rr_ptr;
    logic [PW-1:0]    grant_idx;
    logic [N_REQ-1:0] eligible;
    logic [N_REQ-1:0] grant;
    logic             any;

    // A full slot that is draining this cycle can take a new result at once.
    assign eligible  = rst_n ? (req_valid & (~rsp_valid | rsp_ready)) : '0;
    assign req_ready = grant;

    rr_pick #(
        .N  (N_REQ),
        .PW (PW)
    ) u_pick (
        .eligible  (eligible),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (any)
    );

    // Idle ALU inputs are forced to zero so the shared ALU does not toggle.
    always_comb begin
        alu_inst_32 = 1'b0;
        alu_a       = '0;
        alu_b       = '0;
        alu_sel     = '0;
        if (any) begin
            alu_inst_32 = req_inst_32[grant_idx];
            alu_a       = req_a[int'(grant_idx)*XLEN +: XLEN];
            alu_b       = req_b[int'(grant_idx)*XLEN +: XLEN];
            alu_sel     = req_op[int'(grant_idx)*ALU_SEL_W +: ALU_SEL_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid  <= '0;
            rsp_result <= '0;
            rr_ptr     <= '0;
        end else begin
            if (any) begin
                rr_ptr <= (int'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + PW'(1);
            end
            for (int i = 0; i < N_REQ; i++) begin
                if (grant[i]) begin
                    rsp_valid[i]                  <= 1'b1;
                    rsp_result[i*XLEN +: XLEN]    <= alu_result;
                end else if (rsp_ready[i]) begin
                    rsp_valid[i] <= 1'b0;
                end
            end
        end
    end

endmodule
